// File: rtl/mem_wr_stage.sv
// MEM/WB pipeline register with stall, flush, sub-word load extraction,
// writeback mux and a saturating retired-instruction counter.
module mem_wr_stage #(
   parameter int DW   = 32,
   parameter int RW   = 5,
   parameter int CNTW = 16
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            mem_valid,
   input  logic [DW-1:0]   mem_dout,
   input  logic [DW-1:0]   mem_alu_result,
   input  logic [RW-1:0]   mem_Rw,
   input  logic            mem_RegWr,
   input  logic            mem_Jump,
   input  logic            mem_MemtoReg,
   input  logic [2:0]      mem_LdMode,
   input  logic [DW-1:0]   mem_pc4,
   input  logic            stall,
   input  logic            flush,
   output logic            wr_valid,
   output logic [RW-1:0]   wr_Rw,
   output logic            wr_RegWr,
   output logic            wr_Jump,
   output logic [DW-1:0]   wr_data,
   output logic [CNTW-1:0] wr_retired
);

   logic            valid_q, valid_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic [DW-1:0]   alu_q, alu_d;
   logic [DW-1:0]   pc4_q, pc4_d;
   logic [2:0]      mode_q, mode_d;
   logic [1:0]      off_q, off_d;
   logic [RW-1:0]   rw_q, rw_d;
   logic            regwr_q, regwr_d;
   logic            jump_q, jump_d;
   logic            m2r_q, m2r_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      valid_d = valid_q;
      dout_d  = dout_q;
      alu_d   = alu_q;
      pc4_d   = pc4_q;
      mode_d  = mode_q;
      off_d   = off_q;
      rw_d    = rw_q;
      regwr_d = regwr_q;
      jump_d  = jump_q;
      m2r_d   = m2r_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         regwr_d = 1'b0;
         jump_d  = 1'b0;
         m2r_d   = 1'b0;
      end else if (!stall) begin
         valid_d = mem_valid;
         dout_d  = mem_dout;
         alu_d   = mem_alu_result;
         pc4_d   = mem_pc4;
         mode_d  = mem_LdMode;
         off_d   = mem_alu_result[1:0];
         rw_d    = mem_Rw;
         regwr_d = mem_RegWr;
         jump_d  = mem_Jump;
         m2r_d   = mem_MemtoReg;
         if (mem_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         valid_q <= 1'b0;
         dout_q  <= '0;
         alu_q   <= '0;
         pc4_q   <= '0;
         mode_q  <= '0;
         off_q   <= '0;
         rw_q    <= '0;
         regwr_q <= 1'b0;
         jump_q  <= 1'b0;
         m2r_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dout_q  <= dout_d;
         alu_q   <= alu_d;
         pc4_q   <= pc4_d;
         mode_q  <= mode_d;
         off_q   <= off_d;
         rw_q    <= rw_d;
         regwr_q <= regwr_d;
         jump_q  <= jump_d;
         m2r_q   <= m2r_d;
         cnt_q   <= cnt_d;
      end
   end

   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [DW-1:0] ld_data;

   // Little-endian lanes; halfword ignores off[0] (no misalignment trap)
   assign byte_sel = dout_q[{off_q, 3'b000} +: 8];
   assign half_sel = dout_q[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = dout_q;
      case (mode_q)
         3'b001:  ld_data = {{(DW-8){byte_sel[7]}}, byte_sel};
         3'b010:  ld_data = {{(DW-8){1'b0}}, byte_sel};
         3'b011:  ld_data = {{(DW-16){half_sel[15]}}, half_sel};
         3'b100:  ld_data = {{(DW-16){1'b0}}, half_sel};
         default: ld_data = dout_q;
      endcase
   end

   always_comb begin
      if (jump_q) begin
         wr_data = pc4_q;
      end else if (m2r_q) begin
         wr_data = ld_data;
      end else begin
         wr_data = alu_q;
      end
   end

   assign wr_valid   = valid_q;
   assign wr_Rw      = rw_q;
   assign wr_RegWr   = regwr_q & valid_q;
   assign wr_Jump    = jump_q;
   assign wr_retired = cnt_q;

endmodule

// File: tb/tb_mem_wr_stage.sv
// Bench for mem_wr_stage: directed plan steps then randomized traffic
// checked against a field-level reference model.
module tb_mem_wr_stage;

   logic        Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Rst_n, mem_valid, mem_RegWr, mem_Jump, mem_MemtoReg;
   logic        stall, flush;
   logic [31:0] mem_dout, mem_alu_result, mem_pc4;
   logic [4:0]  mem_Rw;
   logic [2:0]  mem_LdMode;

   logic        wr_valid, wr_RegWr, wr_Jump;
   logic [4:0]  wr_Rw;
   logic [31:0] wr_data;
   logic [15:0] wr_retired;

   logic        s_valid, s_RegWr, s_Jump;
   logic [4:0]  s_Rw;
   logic [31:0] s_data;
   logic [1:0]  s_retired;

   mem_wr_stage #(.DW(32), .RW(5), .CNTW(16)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .mem_valid(mem_valid),
      .mem_dout(mem_dout), .mem_alu_result(mem_alu_result),
      .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr), .mem_Jump(mem_Jump),
      .mem_MemtoReg(mem_MemtoReg), .mem_LdMode(mem_LdMode),
      .mem_pc4(mem_pc4), .stall(stall), .flush(flush),
      .wr_valid(wr_valid), .wr_Rw(wr_Rw), .wr_RegWr(wr_RegWr),
      .wr_Jump(wr_Jump), .wr_data(wr_data), .wr_retired(wr_retired)
   );

   mem_wr_stage #(.DW(32), .RW(5), .CNTW(2)) dut_sat (
      .Clk(Clk), .Rst_n(Rst_n), .mem_valid(mem_valid),
      .mem_dout(mem_dout), .mem_alu_result(mem_alu_result),
      .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr), .mem_Jump(mem_Jump),
      .mem_MemtoReg(mem_MemtoReg), .mem_LdMode(mem_LdMode),
      .mem_pc4(mem_pc4), .stall(stall), .flush(flush),
      .wr_valid(s_valid), .wr_Rw(s_Rw), .wr_RegWr(s_RegWr),
      .wr_Jump(s_Jump), .wr_data(s_data), .wr_retired(s_retired)
   );

   int checks = 0;
   int errors = 0;

   // reference model: the instruction currently sitting in WR
   logic        m_valid, m_regwr, m_jump, m_m2r;
   logic [4:0]  m_rw;
   logic [2:0]  m_mode;
   logic [31:0] m_dout, m_alu, m_pc4;
   int          m_cnt, m_cnt2;

   function automatic logic [31:0] ref_data();
      logic [31:0] off, b, h;
      off = m_alu % 4;
      b   = (m_dout >> (8 * off)) % 256;
      h   = (m_dout >> (16 * (off / 2))) % 65536;
      if (m_jump) return m_pc4;
      if (!m_m2r) return m_alu;
      case (m_mode)
         3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return h;
         default: return m_dout;
      endcase
   endfunction

   task automatic model_edge();
      if (!Rst_n) begin
         m_valid = 0; m_regwr = 0; m_jump = 0; m_m2r = 0;
         m_rw = 0; m_mode = 0; m_dout = 0; m_alu = 0; m_pc4 = 0;
         m_cnt = 0; m_cnt2 = 0;
      end else if (flush) begin
         m_valid = 0; m_regwr = 0; m_jump = 0; m_m2r = 0;
      end else if (!stall) begin
         m_valid = mem_valid;  m_regwr = mem_RegWr;
         m_jump  = mem_Jump;   m_m2r   = mem_MemtoReg;
         m_rw    = mem_Rw;     m_mode  = mem_LdMode;
         m_dout  = mem_dout;   m_alu   = mem_alu_result;
         m_pc4   = mem_pc4;
         if (mem_valid) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("valid", 32'(wr_valid), 32'(m_valid));
      chk("regwr", 32'(wr_RegWr), 32'(m_regwr & m_valid));
      chk("jump", 32'(wr_Jump), 32'(m_jump));
      chk("retired", 32'(wr_retired), 32'(m_cnt));
      chk("retired_sat", 32'(s_retired), 32'(m_cnt2));
      if (m_valid) begin
         chk("rw", 32'(wr_Rw), 32'(m_rw));
         chk("data", wr_data, ref_data());
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check_all();
   endtask

   task automatic drive(input logic v, input logic [31:0] dout,
                        input logic [31:0] alu, input logic [4:0] rw,
                        input logic rwe, input logic j, input logic m2r,
                        input logic [2:0] mode, input logic [31:0] pc4);
      mem_valid = v; mem_dout = dout; mem_alu_result = alu;
      mem_Rw = rw; mem_RegWr = rwe; mem_Jump = j;
      mem_MemtoReg = m2r; mem_LdMode = mode; mem_pc4 = pc4;
   endtask

   initial begin
      Rst_n = 0; stall = 0; flush = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);

      // 1: reset then pass-through
      tick(); tick();
      chk("rst_data", wr_data, 32'h0);
      chk("rst_rw", 32'(wr_Rw), 32'h0);
      Rst_n = 1;
      drive(1, 0, 32'h1234, 5, 1, 0, 0, 0, 0);
      tick();
      chk("pass_data", wr_data, 32'h1234);
      chk("pass_rw", 32'(wr_Rw), 32'd5);
      chk("pass_regwr", 32'(wr_RegWr), 32'd1);
      chk("pass_ret", 32'(wr_retired), 32'd1);

      // 2: sub-word loads
      drive(1, 32'h80FF7F01, 32'h103, 7, 1, 0, 1, 3'b001, 0);
      tick(); chk("lb_s3", wr_data, 32'hFFFFFF80);
      mem_LdMode = 3'b010;
      tick(); chk("lb_u3", wr_data, 32'h00000080);
      mem_LdMode = 3'b011; mem_alu_result = 32'h102;
      tick(); chk("lh_s2", wr_data, 32'hFFFF80FF);
      mem_LdMode = 3'b100; mem_alu_result = 32'h100;
      tick(); chk("lh_u0", wr_data, 32'h00007F01);
      mem_LdMode = 3'b000;
      tick(); chk("lw", wr_data, 32'h80FF7F01);

      // 3: stall holds A while B waits
      drive(1, 0, 32'hA, 3, 1, 0, 0, 0, 0);
      tick();
      stall = 1;
      drive(1, 0, 32'hB, 9, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rw", 32'(wr_Rw), 32'd3);
         chk("stall_ret", 32'(wr_retired), 32'd7);
      end
      stall = 0;
      tick();
      chk("unstall_rw", 32'(wr_Rw), 32'd9);
      chk("unstall_data", wr_data, 32'hB);

      // 4: flush beats stall
      stall = 1; flush = 1;
      drive(1, 0, 32'hC, 4, 1, 0, 0, 0, 0);
      tick();
      chk("flush_valid", 32'(wr_valid), 32'd0);
      chk("flush_regwr", 32'(wr_RegWr), 32'd0);
      chk("flush_ret", 32'(wr_retired), 32'd8);
      stall = 0; flush = 0;

      // 5: jump link
      drive(1, 32'hDEADBEEF, 32'h99, 1, 1, 1, 1, 0, 32'h44);
      tick();
      chk("jal_data", wr_data, 32'h44);
      chk("jal_jump", 32'(wr_Jump), 32'd1);

      // 6: counter saturation on the CNTW=2 instance
      Rst_n = 0; tick(); Rst_n = 1;
      drive(1, 0, 32'h1, 2, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("sat_cnt", 32'(s_retired), (i < 3) ? 32'(i) : 32'd3);
      end
      Rst_n = 0; tick();
      chk("sat_rst", 32'(s_retired), 32'd0);
      Rst_n = 1;

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         Rst_n = ($urandom_range(0, 59) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom,
               5'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
               1'($urandom), 3'($urandom), $urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wr_stage.md
Name: mem_wr_stage

Overview:
- Parametrised MEM/WB pipeline register for the 5-stage pipeline, successor to the fixed 32-bit MEM→WR latch.
- Adds stall (hold), flush (bubble insert) and a valid bit per stage entry.
- Adds sub-word load extraction (byte/half, signed/unsigned) and the writeback-data mux, so WR-stage logic and the forwarding unit see final register-file data.
- Includes a saturating retired-instruction counter for bench and debug visibility.

Parameters:
- DW, 32: datapath width; must be 32 for sub-word modes to be meaningful.
- RW, 5: register-address width.
- CNTW, 16: retired-instruction counter width.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  synchronous active-low reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_dout  in  DW  data-memory read word
- mem_alu_result  in  DW  ALU result; low 2 bits are the load byte offset
- mem_Rw  in  RW  destination register
- mem_RegWr  in  1  register write enable
- mem_Jump  in  1  jump-and-link marker
- mem_MemtoReg  in  1  select load data
- mem_LdMode  in  3  load mode: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; others treated as word
- mem_pc4  in  DW  PC+4 for link write
- stall  in  1  hold current WR contents
- flush  in  1  insert bubble
- wr_valid  out  1  WR entry valid
- wr_Rw  out  RW  destination register
- wr_RegWr  out  1  qualified write enable (RegWr AND valid)
- wr_Jump  out  1  jump marker, registered
- wr_data  out  DW  final writeback value
- wr_retired  out  CNTW  count of valid entries accepted

Behaviour:
- Reset (Rst_n=0 at a rising edge): all outputs and internal registers go to 0. Reset has priority over flush and stall.
- Priority at each rising edge: reset > flush > stall > load.
- Flush: wr_valid=0, internal RegWr=0, Jump=0, MemtoReg=0. Data fields may keep old values, but wr_RegWr must be 0.
- Stall: every register holds its value and the counter does not increment.
- Load: capture mem_* fields; wr_valid <= mem_valid.
- Latency: exactly one cycle from the MEM inputs to the WR outputs.
- wr_RegWr is combinational from registered state: internal RegWr AND wr_valid. A stored RegWr with valid=0 never writes.
- Registered internal state: dout, alu_result, pc4, LdMode, the offset alu_result[1:0], Rw, RegWr, Jump, MemtoReg, valid.
- Load extraction is combinational on registered values and uses little-endian offsets.
  - Byte: dout[8*off+7 : 8*off].
  - Half: off[1]=0 selects bits [15:0]; off[1]=1 selects [31:16]. off[0] is ignored; no misalignment trap.
  - Signed modes replicate the MSB of the selected field; unsigned modes zero-fill to DW.
- wr_data selection: Jump=1 → pc4; else MemtoReg=1 → extracted load data; else alu_result.
- Counter: increments on an edge where the load path is taken with mem_valid=1. It saturates at all-ones and never wraps; it is cleared only by reset.
- Simultaneous stall and flush: flush wins and a bubble is inserted.
- A reset asserted mid-stall clears state; the first edge after deassertion resumes normal loading.

Test Plan:
1. Reset then pass-through: Rst_n=0 for 2 cycles → all outputs 0. Then mem_valid=1, alu_result=0x1234, Rw=5, RegWr=1, MemtoReg=0 → next edge wr_data=0x1234, wr_Rw=5, wr_RegWr=1, wr_retired=1.
2. Sub-word loads with dout=0x80FF7F01, MemtoReg=1:
   - LdMode=001, offset 3 → wr_data=0xFFFFFF80.
   - LdMode=010, offset 3 → 0x00000080.
   - LdMode=011, offset 2 → 0xFFFF80FF.
   - LdMode=100, offset 0 → 0x00007F01.
   - LdMode=000 → 0x80FF7F01.
3. Stall: load entry A (Rw=3), then stall=1 for 3 cycles while the inputs change to entry B → outputs stay at A and wr_retired is unchanged. Release stall → B appears one edge later.
4. Flush with stall: stall=1 and flush=1 with a valid RegWr=1 input → wr_valid=0, wr_RegWr=0, counter unchanged.
5. Jump link: Jump=1, pc4=0x00000044, MemtoReg=1 → wr_data=0x44, wr_Jump=1.
6. Counter saturation with CNTW=2: feed 5 valid entries → wr_retired reads 1, 2, 3, 3, 3. Then assert Rst_n=0 → 0.
